// File: rtl/snn_link_pkg.sv
// Shared types and constants for the SNN serial link (image sender side).
package snn_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        WAIT_RESP,
        RECV
    } state_t;

    localparam int IMG_BYTES    = 98;
    localparam int DEF_BAUD_DIV = 5208;

    // A classification byte is unusable if its frame is broken or it is not a decimal digit.
    function automatic logic resp_is_bad(input logic [7:0] resp, input logic stop_bit);
        return !stop_bit || (resp > 8'd9);
    endfunction

endpackage

// File: rtl/snn_ser_tx.sv
// 8N1 serializer: one frame per start pulse, done pulses in the last clock of the stop bit.
module snn_ser_tx
    import snn_link_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    logic          r_busy;
    logic [BW-1:0] r_baud;
    logic [3:0]    r_bit;
    logic [8:0]    r_shift;
    logic          r_tx;
    logic          w_bit_end;

    assign w_bit_end = r_busy && (r_baud == BAUD_LAST);
    // Combinational so the parent can queue the next byte without an extra idle clock.
    assign done      = w_bit_end && (r_bit == 4'd9);
    assign tx        = r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '1;
            r_tx    <= 1'b1;
        end else if (!r_busy) begin
            if (start) begin
                r_busy  <= 1'b1;
                r_tx    <= 1'b0;
                r_shift <= {1'b1, data};
                r_bit   <= '0;
                r_baud  <= '0;
            end
        end else if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 4'd9) begin
                r_busy <= 1'b0;
            end else begin
                r_tx    <= r_shift[0];
                r_shift <= {1'b1, r_shift[8:1]};
                r_bit   <= r_bit + 4'd1;
            end
        end else begin
            r_baud <= r_baud + BW'(1);
        end
    end

endmodule

// File: rtl/snn_img_sender.sv
// Self-test initiator: streams a packed binary image from ROM over tx and collects the digit on rx.
module snn_img_sender
    import snn_link_pkg::*;
#(
    parameter int NUM_BYTES    = IMG_BYTES,
    parameter int BAUD_DIV     = DEF_BAUD_DIV,
    parameter int RESP_TIMEOUT = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    output logic [6:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       tx,
    input  logic       rx,
    output logic       busy,
    output logic       result_vld,
    output logic [3:0] result,
    output logic       bad_resp,
    output logic       timeout
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(RESP_TIMEOUT);
    localparam logic [6:0]    LAST_BYTE = 7'(NUM_BYTES - 1);

    state_t        r_state;
    logic [6:0]    r_cnt;
    logic          r_fetch_wait;
    logic          r_busy;
    logic          r_result_vld;
    logic [3:0]    r_result;
    logic          r_bad_resp;
    logic          r_timeout;
    logic [TW-1:0] r_tmo;
    logic [BW-1:0] r_baud;
    logic [3:0]    r_rbit;
    logic [7:0]    r_shift;
    logic          r_rx_prev;

    logic          w_ser_start;
    logic          w_ser_done;
    logic          w_rx_fall;
    logic          w_sample;
    logic          w_tmo_expired;
    logic [TW-1:0] w_tmo_next;

    assign w_ser_start   = (r_state == FETCH) && r_fetch_wait;
    assign w_rx_fall     = r_rx_prev && !rx;
    // Start bit is checked mid-bit; every later bit one full period after the previous sample.
    assign w_sample      = (r_baud == ((r_rbit == 4'd0) ? BAUD_HALF : BAUD_LAST));
    assign w_tmo_next    = (r_tmo == '0) ? '0 : r_tmo - TW'(1);
    assign w_tmo_expired = (r_tmo <= TW'(1));

    snn_ser_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_ser_start),
        .data  (rom_data),
        .tx    (tx),
        .done  (w_ser_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_fetch_wait <= 1'b0;
            r_busy       <= 1'b0;
            r_result_vld <= 1'b0;
            r_result     <= '0;
            r_bad_resp   <= 1'b0;
            r_timeout    <= 1'b0;
            r_tmo        <= '0;
            r_baud       <= '0;
            r_rbit       <= '0;
            r_shift      <= '0;
            r_rx_prev    <= 1'b1;
        end else begin
            r_rx_prev    <= rx;
            r_result_vld <= 1'b0;
            r_timeout    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_state      <= FETCH;
                        r_cnt        <= '0;
                        r_fetch_wait <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                FETCH: begin
                    // First cycle presents the address, second consumes the ROM word.
                    if (!r_fetch_wait) begin
                        r_fetch_wait <= 1'b1;
                    end else begin
                        r_fetch_wait <= 1'b0;
                        r_state      <= SEND;
                    end
                end
                SEND: begin
                    if (w_ser_done) begin
                        if (r_cnt == LAST_BYTE) begin
                            r_state <= WAIT_RESP;
                            r_tmo   <= TMO_LOAD;
                        end else begin
                            r_cnt   <= r_cnt + 7'd1;
                            r_state <= FETCH;
                        end
                    end
                end
                WAIT_RESP: begin
                    r_tmo <= w_tmo_next;
                    if (w_rx_fall) begin
                        r_state <= RECV;
                        r_baud  <= '0;
                        r_rbit  <= '0;
                    end else if (w_tmo_expired) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                RECV: begin
                    r_tmo <= w_tmo_next;
                    if (w_sample) begin
                        r_baud <= '0;
                        if (r_rbit == 4'd0) begin
                            if (rx) begin
                                r_state <= WAIT_RESP;
                            end else begin
                                r_rbit <= 4'd1;
                            end
                        end else if (r_rbit == 4'd9) begin
                            r_result     <= r_shift[3:0];
                            r_bad_resp   <= resp_is_bad(r_shift, rx);
                            r_result_vld <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= IDLE;
                        end else begin
                            r_shift <= {rx, r_shift[7:1]};
                            r_rbit  <= r_rbit + 4'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rom_addr   = r_cnt;
    assign busy       = r_busy;
    assign result_vld = r_result_vld;
    assign result     = r_result;
    assign bad_resp   = r_bad_resp;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_snn_img_sender.sv
// Bench for snn_img_sender: full 98-byte image instance plus a short-image instance for response vectors.
module tb_snn_img_sender;

    localparam int B0 = 16;
    localparam int N0 = 98;
    localparam int T0 = 500;
    localparam int B1 = 17;
    localparam int N1 = 4;
    localparam int T1 = 300;

    typedef struct {
        logic [7:0] rbyte;
        logic       stop;
        logic       glitch;
        logic [3:0] exp_res;
        logic       exp_bad;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a  [2];
    logic       go_a   [2];
    logic       rx_a   [2];
    logic [6:0] addr_a [2];
    logic [7:0] data_a [2];
    logic       tx_a   [2];
    logic       busy_a [2];
    logic       vld_a  [2];
    logic [3:0] res_a  [2];
    logic       bad_a  [2];
    logic       tmo_a  [2];

    logic [7:0] rom_mem [0:127];
    vec_t       tbl [7];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mon_vld, mon_tmo;
    logic [3:0] mon_res;
    logic       mon_bad, mon_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        data_a[0] <= rom_mem[addr_a[0]];
        data_a[1] <= rom_mem[addr_a[1]];
    end

    snn_img_sender #(.NUM_BYTES(N0), .BAUD_DIV(B0), .RESP_TIMEOUT(T0)) u_dut (
        .clk(clk), .rst_n(rst_a[0]), .go(go_a[0]), .rom_addr(addr_a[0]), .rom_data(data_a[0]),
        .tx(tx_a[0]), .rx(rx_a[0]), .busy(busy_a[0]), .result_vld(vld_a[0]), .result(res_a[0]),
        .bad_resp(bad_a[0]), .timeout(tmo_a[0]));

    snn_img_sender #(.NUM_BYTES(N1), .BAUD_DIV(B1), .RESP_TIMEOUT(T1)) u_dut_short (
        .clk(clk), .rst_n(rst_a[1]), .go(go_a[1]), .rom_addr(addr_a[1]), .rom_data(data_a[1]),
        .tx(tx_a[1]), .rx(rx_a[1]), .busy(busy_a[1]), .result_vld(vld_a[1]), .result(res_a[1]),
        .bad_resp(bad_a[1]), .timeout(tmo_a[1]));

    function automatic int bdiv(input int d);
        return (d == 0) ? B0 : B1;
    endfunction

    function automatic int nbytes(input int d);
        return (d == 0) ? N0 : N1;
    endfunction

    // Expected response: low nibble of the byte; bad unless a clean frame carrying 0..9.
    function automatic logic [4:0] model_resp(input logic [7:0] b, input logic stop);
        int  v;
        logic bad;
        v   = int'(b);
        bad = (stop == 1'b0) || (v > 9);
        return {bad, 4'(v % 16)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int d);
        @(negedge clk);
        if (vld_a[d] === 1'b1) begin
            mon_vld++;
            mon_res  = res_a[d];
            mon_bad  = bad_a[d];
            mon_busy = busy_a[d];
        end
        if (tmo_a[d] === 1'b1) mon_tmo++;
    endtask

    task automatic start_image(input int d);
        @(negedge clk);
        go_a[d] = 1'b1;
        @(negedge clk);
        go_a[d] = 1'b0;
        check($sformatf("busy after go dut%0d", d), busy_a[d], 1);
    endtask

    // Decodes every frame on tx cycle by cycle; optionally pulses go or asserts reset mid-image.
    task automatic run_image(input int d, input int go_at, input int rst_at);
        int bd, nb, g, t0;
        logic [7:0] got;
        logic [9:0] fr;
        logic [6:0] addr_seen;
        logic terr;
        bd = bdiv(d);
        nb = nbytes(d);
        t0 = cyc;
        g  = 0;
        while (tx_a[d] !== 1'b0 && g < 8) begin
            @(negedge clk);
            g++;
        end
        check($sformatf("first start bit dut%0d", d), tx_a[d], 0);
        for (int i = 0; i < nb; i++) begin
            got       = '0;
            terr      = 1'b0;
            addr_seen = '0;
            fr        = {1'b1, rom_mem[i], 1'b0};
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < bd; c++) begin
                    go_a[d] = (i == go_at && b == 3 && c == 0);
                    if (i == rst_at && b == 4 && c == 5) begin
                        rst_a[d] = 1'b0;
                        #1;
                        check("tx high at reset mid-frame", tx_a[d], 1);
                        check("busy low at reset mid-frame", busy_a[d], 0);
                        check("rom_addr at reset mid-frame", addr_a[d], 0);
                        return;
                    end
                    if (tx_a[d] !== fr[b]) terr = 1'b1;
                    if (c == bd / 2 && b >= 1 && b <= 8) got[b-1] = tx_a[d];
                    if (c == 0 && b == 5) addr_seen = addr_a[d];
                    @(negedge clk);
                end
            end
            check($sformatf("tx byte %0d dut%0d", i, d), got, rom_mem[i]);
            check($sformatf("bit timing byte %0d dut%0d", i, d), terr, 0);
            check($sformatf("rom_addr byte %0d dut%0d", i, d), addr_seen, i);
            if (i < nb - 1) begin
                g = 0;
                while (tx_a[d] !== 1'b0 && g < 4) begin
                    @(negedge clk);
                    g++;
                end
                check($sformatf("inter-byte gap <=3 after byte %0d dut%0d", i, d), g, (g <= 3) ? g : 3);
            end
        end
        check($sformatf("send time bound dut%0d", d), int'(cyc - t0 <= nb * (10 * bd + 3)), 1);
    endtask

    task automatic send_rx(input int d, input logic [7:0] b, input logic stop, input logic glitch);
        int bd;
        logic [9:0] fr;
        bd      = bdiv(d);
        fr      = {stop, b, 1'b0};
        mon_vld = 0;
        mon_tmo = 0;
        repeat ($urandom_range(0, 40)) step(d);
        if (glitch) begin
            rx_a[d] = 1'b0;
            repeat (3) step(d);
            rx_a[d] = 1'b1;
            repeat (40) step(d);
            check($sformatf("glitch gives no result_vld dut%0d", d), mon_vld, 0);
            check($sformatf("busy held after glitch dut%0d", d), busy_a[d], 1);
        end
        for (int k = 0; k < 10; k++) begin
            rx_a[d] = fr[k];
            repeat (bd) step(d);
        end
        rx_a[d] = 1'b1;
        repeat (4) step(d);
    endtask

    task automatic check_resp(input int d, input logic [3:0] exp_res, input logic exp_bad);
        check($sformatf("result_vld cycles dut%0d", d), mon_vld, 1);
        check($sformatf("result dut%0d", d), mon_res, exp_res);
        check($sformatf("bad_resp dut%0d", d), mon_bad, exp_bad);
        check($sformatf("busy at result_vld dut%0d", d), mon_busy, 0);
        check($sformatf("no timeout during response dut%0d", d), mon_tmo, 0);
        check($sformatf("result held dut%0d", d), res_a[d], exp_res);
    endtask

    task automatic wait_timeout(input int d, input int tmo, input logic [3:0] exp_res, input logic exp_bad);
        int k;
        k = 0;
        while (tmo_a[d] !== 1'b1 && k < 2 * tmo) begin
            @(negedge clk);
            k++;
        end
        check("timeout latency after last stop bit", k, tmo);
        check("busy low at timeout", busy_a[d], 0);
        check("result kept over timeout", res_a[d], exp_res);
        check("bad_resp kept over timeout", bad_a[d], exp_bad);
        check("no result_vld at timeout", vld_a[d], 0);
        @(negedge clk);
        check("timeout single cycle", tmo_a[d], 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int e;
        logic [7:0] rb;
        logic rs, rg;
        logic [4:0] m;

        tbl[0] = '{8'h07, 1'b1, 1'b0, 4'h7, 1'b0};
        tbl[1] = '{8'h0C, 1'b1, 1'b0, 4'hC, 1'b1};
        tbl[2] = '{8'h03, 1'b0, 1'b0, 4'h3, 1'b1};
        tbl[3] = '{8'h09, 1'b1, 1'b1, 4'h9, 1'b0};
        tbl[4] = '{8'h0A, 1'b1, 1'b0, 4'hA, 1'b1};
        tbl[5] = '{8'hF5, 1'b1, 1'b0, 4'h5, 1'b1};
        tbl[6] = '{8'h00, 1'b1, 1'b0, 4'h0, 1'b0};

        for (int i = 0; i < 128; i++) rom_mem[i] = 8'(i);
        for (int d = 0; d < 2; d++) begin
            rst_a[d] = 1'b0;
            go_a[d]  = 1'b0;
            rx_a[d]  = 1'b1;
        end

        repeat (5) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset tx dut%0d", d), tx_a[d], 1);
            check($sformatf("reset busy dut%0d", d), busy_a[d], 0);
            check($sformatf("reset rom_addr dut%0d", d), addr_a[d], 0);
            check($sformatf("reset result_vld dut%0d", d), vld_a[d], 0);
            check($sformatf("reset result dut%0d", d), res_a[d], 0);
            check($sformatf("reset bad_resp dut%0d", d), bad_a[d], 0);
            check($sformatf("reset timeout dut%0d", d), tmo_a[d], 0);
            rst_a[d] = 1'b1;
        end
        e = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || addr_a[0] !== 7'd0) e++;
        end
        check("idle 1000 clocks bad cycles", e, 0);

        // Full image with a stray go during byte 20, then a good digit.
        start_image(0);
        run_image(0, 20, -1);
        send_rx(0, 8'h07, 1'b1, 1'b0);
        check_resp(0, 4'h7, 1'b0);

        // No response: timeout after the window, result untouched.
        start_image(0);
        run_image(0, -1, -1);
        wait_timeout(0, T0, 4'h7, 1'b0);

        // Restart from byte 0, reset during byte 40.
        start_image(0);
        run_image(0, -1, 40);
        repeat (3) @(negedge clk);
        rst_a[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("tx idle after reset release", tx_a[0], 1);
        check("busy low after reset release", busy_a[0], 0);
        check("rom_addr after reset release", addr_a[0], 0);

        // Fresh image after reset; glitch then broken-stop response.
        start_image(0);
        run_image(0, -1, -1);
        send_rx(0, 8'h03, 1'b0, 1'b1);
        check_resp(0, 4'h3, 1'b1);

        // Response vectors on the short-image instance.
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < N1; i++) rom_mem[i] = 8'($urandom);
            start_image(1);
            run_image(1, -1, -1);
            send_rx(1, tbl[t].rbyte, tbl[t].stop, tbl[t].glitch);
            check_resp(1, tbl[t].exp_res, tbl[t].exp_bad);
        end
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N1; i++) rom_mem[i] = 8'($urandom);
            rb = 8'($urandom_range(0, 255));
            if (r < 3) rb = 8'($urandom_range(0, 15));
            rs = ($urandom_range(0, 3) != 0);
            rg = (r == 2);
            m  = model_resp(rb, rs);
            start_image(1);
            run_image(1, -1, -1);
            send_rx(1, rb, rs, rg);
            check_resp(1, m[3:0], m[4]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
